// File: rtl/cache_l1_dm.sv
// cache_l1_dm -- direct-mapped, write-back, write-allocate L1 cache for the
// multicycle RV32I core.
//
// It serves word-wide core requests from 32-byte lines. On a miss, a dirty
// victim line is written back first. The line is then filled from the
// 256-bit physical memory port. The request is retried from IDLE after the
// fill and then hits.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_read/mem_write  core request (write wins if both), held until mem_resp
//   mem_byte_enable     byte lanes written on a write
//   mem_address         byte address (bits [1:0] ignored)
//   mem_wdata           write data
//   mem_rdata           read data, valid while mem_resp=1 on a read
//   mem_resp            one-cycle completion pulse
//   pmem_read/write     line read/write request, held until pmem_resp
//   pmem_address        line address (bits [4:0] = 0)
//   pmem_wdata          evicted line
//   pmem_rdata          fill line, sampled on the pmem_resp cycle
//   pmem_resp           physical memory completion
module cache_l1_dm #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_e;

  state_e              state_q, state_d;
  logic [SETS-1:0]     valid_q, dirty_q;
  logic [31:0]         mem_rdata_q;

  // Tag and line storage are not reset; validity is carried by valid_q.
  logic [TAG_W-1:0]    tag_mem  [SETS];
  logic [255:0]        data_mem [SETS];

  logic [TAG_W-1:0]    req_tag;
  logic [S_INDEX-1:0]  req_idx;
  logic [2:0]          req_word;
  logic [7:0]          word_lsb;
  logic [TAG_W-1:0]    cur_tag;
  logic [255:0]        cur_line;
  logic [31:0]         cur_word;
  logic [31:0]         merged_word;
  logic                hit;
  logic                hit_rd, hit_wr, fill_done;
  logic [1:0]          unused_addr_bits;

  assign req_tag  = mem_address[31:5+S_INDEX];
  assign req_idx  = mem_address[4+S_INDEX:5];
  assign req_word = mem_address[4:2];
  assign word_lsb = {req_word, 5'b0};
  assign unused_addr_bits = mem_address[1:0];

  assign cur_tag  = tag_mem[req_idx];
  assign cur_line = data_mem[req_idx];
  assign cur_word = cur_line[word_lsb +: 32];
  assign hit      = valid_q[req_idx] && (cur_tag == req_tag);

  // Byte-lane merge of the write data into the currently stored word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_word[8*gi +: 8] = mem_byte_enable[gi] ? mem_wdata[8*gi +: 8]
                                                        : cur_word[8*gi +: 8];
  end

  // Next-state logic and single-cycle action strobes.
  always_comb begin
    state_d   = state_q;
    hit_rd    = 1'b0;
    hit_wr    = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            state_d = RESP;
            if (mem_write) hit_wr = 1'b1;
            else           hit_rd = 1'b1;
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = WB;
          end else begin
            state_d = FILL;
          end
        end
      end
      WB: begin
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        if (pmem_resp) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (hit_rd) mem_rdata_q <= cur_word;
      if (hit_wr) dirty_q[req_idx] <= 1'b1;
      if (fill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[req_idx] <= pmem_rdata;
      tag_mem[req_idx]  <= req_tag;
    end else if (hit_wr) begin
      data_mem[req_idx][word_lsb +: 32] <= merged_word;
    end
  end

  // Moore outputs. The request address is held by the core, so the
  // pmem address and victim data stay stable while WB/FILL wait.
  assign mem_resp     = (state_q == RESP);
  assign mem_rdata    = mem_rdata_q;
  assign pmem_write   = (state_q == WB);
  assign pmem_read    = (state_q == FILL);
  assign pmem_address = (state_q == WB) ? {cur_tag, req_idx, 5'b0}
                                        : {req_tag, req_idx, 5'b0};
  assign pmem_wdata   = cur_line;

endmodule
